// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between NREQ requesters, the FIFO write side and fifo_wr_arbiter.
// The master drives requests and FIFO flags; the slave (the arbiter) drives grants and the write.
interface fifo_wr_arbiter_if #(
    parameter int DATASIZE = 8,
    parameter int NREQ     = 4
);
    logic [NREQ-1:0]          req_i;
    logic [NREQ*DATASIZE-1:0] data_i;
    logic [NREQ-1:0]          last_i;
    logic [NREQ-1:0]          ack_o;
    logic [NREQ-1:0]          gnt_o;
    logic [DATASIZE-1:0]      wdata_o;
    logic                     winc_o;
    logic                     wfull_i;
    logic                     w_almost_full_i;
    logic                     busy_o;

    modport master (
        output req_i, data_i, last_i, wfull_i, w_almost_full_i,
        input  ack_o, gnt_o, wdata_o, winc_o, busy_o
    );

    modport slave (
        input  req_i, data_i, last_i, wfull_i, w_almost_full_i,
        output ack_o, gnt_o, wdata_o, winc_o, busy_o
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-burst arbiter for the single write port of the async FIFO.
// Lives in the write-clock domain; the write itself is combinational so wfull_i stalls same-cycle.
module fifo_wr_arbiter #(
    parameter int DATASIZE = 8,
    parameter int NREQ     = 4,
    parameter int MAXBURST = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    fifo_wr_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, BURST} state_e;

    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(MAXBURST + 1);

    state_e              state_q;
    logic [NREQ-1:0]     gnt_q;
    logic [PTR_W-1:0]    rr_ptr_q;
    logic [PTR_W-1:0]    rr_ptr_d;
    logic [CNT_W-1:0]    beat_cnt_q;
    logic [CNT_W-1:0]    beat_cnt_d;

    logic [PTR_W-1:0]    owner_ptr;
    logic                owner_req;
    logic                owner_last;
    logic [DATASIZE-1:0] owner_data;
    logic [PTR_W-1:0]    scan_idx;
    logic [PTR_W-1:0]    winner_ptr;
    logic                winner_found;
    logic                accept;
    logic                release_burst;

    // gnt_q is one-hot or zero, so an OR-mux over its bits selects the owner.
    always_comb begin
        // NOTE: every always_comb output gets a default first, otherwise a path that skips the assignment infers a latch.
        owner_ptr  = '0;
        owner_req  = 1'b0;
        owner_last = 1'b0;
        owner_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                owner_ptr  = PTR_W'(i);
                owner_req  = bus.req_i[i];
                owner_last = bus.last_i[i];
                owner_data = bus.data_i[i*DATASIZE +: DATASIZE];
            end
        end
    end

    always_comb begin
        winner_found = 1'b0;
        winner_ptr   = '0;
        scan_idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan_idx = PTR_W'((int'(rr_ptr_q) + i) % NREQ);
            if (!winner_found && bus.req_i[scan_idx]) begin
                winner_found = 1'b1;
                winner_ptr   = scan_idx;
            end
        end
    end

    assign accept        = owner_req & ~bus.wfull_i;
    assign release_burst = ~owner_req
                         | (accept & (owner_last | (beat_cnt_q == CNT_W'(MAXBURST - 1))));
    assign rr_ptr_d      = (owner_ptr == PTR_W'(NREQ - 1)) ? '0 : owner_ptr + PTR_W'(1);
    assign beat_cnt_d    = accept ? beat_cnt_q + CNT_W'(1) : beat_cnt_q;

    assign bus.winc_o  = accept;
    assign bus.ack_o   = gnt_q & {NREQ{accept}};
    assign bus.gnt_o   = gnt_q;
    assign bus.wdata_o = owner_data;
    assign bus.busy_o  = (state_q == BURST);

    always_ff @(posedge clk_i) begin
        // NOTE: reset is synchronous, so it is an ordinary priority branch inside the clocked block; sequential state uses <= only.
        if (rst_i) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (winner_found && !bus.w_almost_full_i) begin
                        gnt_q      <= NREQ'(1) << winner_ptr;
                        beat_cnt_q <= '0;
                        state_q    <= BURST;
                    end
                end
                BURST: begin
                    beat_cnt_q <= beat_cnt_d;
                    if (release_burst) begin
                        gnt_q    <= '0;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of the asynchronous I2C FIFO among NREQ requesters, such as register-file writes and the DMA engine. It lives entirely in the FIFO write-clock domain and drives the FIFO's write data and write-increment inputs directly. It grants the port in packet-oriented bursts and never asserts a write while the FIFO reports full. It also gates new bursts on the FIFO's almost-full flag.

## Interface
Parameters:
- DATASIZE, 8, width of one FIFO word; must match the FIFO's data width
- NREQ, 4, number of requesters (≥2)
- MAXBURST, 8, maximum beats per grant before forced release (≥1)

Ports:
- clk_i  in  1  write-domain clock; same net as the FIFO write clock
- rst_i  in  1  synchronous, active-high reset
- req_i  in  NREQ  requester k holds a valid beat
- data_i  in  NREQ*DATASIZE  beat of requester k on bits [k*DATASIZE +: DATASIZE]
- last_i  in  NREQ  requester k's current beat is the last of its packet
- ack_o  out  NREQ  beat of requester k accepted this cycle; at most one bit set
- gnt_o  out  NREQ  one-hot current owner of the write port; zero when idle
- wdata_o  out  DATASIZE  to FIFO write data
- winc_o  out  1  to FIFO write increment
- wfull_i  in  1  from FIFO full flag
- w_almost_full_i  in  1  from FIFO almost-full flag
- busy_o  out  1  high while a burst is in progress (state BURST)

## Operation
State machine with two states, IDLE and BURST. Registered state: state, gnt (one-hot), rr_ptr (clog2(NREQ) bits), beat_cnt (clog2(MAXBURST+1) bits).

- **IDLE**
  - Arbitration takes place only if req_i ≠ 0 and w_almost_full_i = 0.
  - Winner: first set req bit scanning upward from rr_ptr, wrapping modulo NREQ.
  - At the next edge: gnt ← onehot(winner), beat_cnt ← 0, state ← BURST.
  - If req_i = 0 or w_almost_full_i = 1, remain in IDLE with gnt = 0.
- **BURST** (owner k = index of the gnt bit)
  - Combinational outputs: accept = req_i[k] & ~wfull_i; winc_o = accept; ack_o = gnt & {NREQ{accept}}; wdata_o = data_i slice k.
  - On accept, beat_cnt increments.
  - Release conditions, evaluated each cycle:
    - (a) accept & last_i[k];
    - (b) accept & beat_cnt = MAXBURST−1;
    - (c) req_i[k] = 0, meaning the requester withdrew; no beat is written.
  - On release, at the next edge: gnt ← 0, rr_ptr ← (k+1) mod NREQ, state ← IDLE.
  - w_almost_full_i is ignored during BURST; only wfull_i stalls.
  - While wfull_i = 1 with req_i[k] = 1, the grant is held indefinitely, with no timeout. winc_o and ack_o stay 0 and the beat stays on data_i.
- **Outside BURST:** winc_o = 0, ack_o = 0, and wdata_o = 0.
- **Reset (any cycle, including mid-burst):** after the edge, state = IDLE, gnt_o = 0, rr_ptr = 0, beat_cnt = 0, busy_o = 0, winc_o = 0, ack_o = 0, wdata_o = 0. A partial packet is abandoned; the requester must restart it.
- **Requester contract:** data_i and last_i for requester k must be stable while req_i[k] = 1 and ack_o[k] = 0.

## Timing
- **Grant latency:** req_i rises in IDLE in cycle n, so gnt_o and busy_o are high in cycle n+1. The first winc_o can occur in cycle n+1.
- **Burst length:** a burst of L beats with no stalls asserts winc_o for L consecutive cycles.
- **Release:** gnt_o drops in the cycle after the releasing beat. That cycle is IDLE, in which the next winner is chosen. The next gnt_o rises one cycle later.
- **Throughput:**
  - Back-to-back bursts pay exactly one idle cycle, giving L/(L+1).
  - Single-beat packets yield one write every 2 cycles.
- **Stalls:** wfull_i affects winc_o and ack_o in the same cycle, with no registered delay.
- **FIFO interaction:** the write pointer advances on the edge where winc_o = 1. The full flag reflects that write from the next cycle onward.

## Test plan
- **Reset:** hold rst_i for 2 cycles with req_i = 4'b1111.
  - Required: gnt_o = 0, winc_o = 0, ack_o = 0 during reset.
  - Required: 1 cycle after rst_i drops, gnt_o = 4'b0001.
- **Round robin:** all four requesters stream single-beat packets with last_i = 1.
  - Required: gnt_o cycles 0001, 0010, 0100, 1000, 0001, one grant every 2 cycles.
  - Required: winc_o is high every other cycle, and the FIFO receives data in requester order.
- **Burst cap:** MAXBURST = 8; requester 1 streams with last_i = 0 while requester 2 waits.
  - Required: exactly 8 winc_o pulses with gnt_o = 0010, then 1 idle cycle, then gnt_o = 0100.
- **Full stall:** wfull_i is forced high for 3 cycles mid-burst.
  - Required: winc_o = 0 and ack_o = 0 for those 3 cycles, with gnt_o held.
  - Required: after the stall, the FIFO contents equal the sequence sent, with no loss or duplication.
- **Almost full and withdrawal:**
  - With w_almost_full_i = 1 in IDLE and req_i = 0001, there is no grant. Deasserting w_almost_full_i gives a grant the next cycle.
  - If a requester drops req_i mid-burst, gnt_o is released the next cycle with no extra write.
- **Reset mid-burst:** assert rst_i after beat 3 of requester 2.
  - Required: gnt_o = 0, busy_o = 0, and rr_ptr = 0 at the next cycle.
  - Required: with all requesting after reset, the first grant goes to requester 0.
